fp8_add_arbiter: RTL

FP8_ADD_ARBITER -- requirements
Module: fp8_add_arbiter

---
 rtl/fp8_add_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/fp8_add_arbiter.sv
// Two-requester arbiter in front of a shared, externally pipelined FP8 adder.
// Define FP8_ARB_FIXED_PRIO_EN for fixed req0-over-req1 priority instead of round-robin.
module fp8_add_arbiter #(
    parameter int unsigned ADD_LATENCY = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic       req1_valid,
    output logic       req0_ready,
    output logic       req1_ready,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    output logic       rsp0_valid,
    output logic       rsp1_valid,
    input  logic       rsp0_ready,
    input  logic       rsp1_ready,
    output logic [7:0] rsp_data,
    output logic [7:0] add_a,
    output logic [7:0] add_b,
    output logic       add_en,
    input  logic [7:0] add_sum
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_t;

    localparam logic [2:0] WaitInit = 3'(ADD_LATENCY - 1);

    state_t     r_state;
    logic       r_gid;
    logic [7:0] r_op_a;
    logic [7:0] r_op_b;
    logic [7:0] r_rsp_data;
    logic [2:0] r_cnt;
    logic       r_first;

    logic w_any;
    logic w_gnt1;
    logic w_grant;
    logic w_add_busy;
    logic w_resp;
    logic w_rsp_hs;

    assign w_any = req0_valid | req1_valid;

`ifdef FP8_ARB_FIXED_PRIO_EN
    assign w_gnt1 = req1_valid & ~req0_valid;
`else
    // Id of the last granted requester; the other one wins a tie.
    logic r_rr_last;

    assign w_gnt1 = req1_valid & (~req0_valid | ~r_rr_last);
`endif

    assign w_grant    = rst_n & (r_state == StIdle) & w_any;
    assign w_add_busy = rst_n & ((r_state == StIssue) | (r_state == StWait));
    assign w_resp     = rst_n & (r_state == StResp);
    assign w_rsp_hs   = r_gid ? rsp1_ready : rsp0_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_gid      <= 1'b0;
            r_op_a     <= 8'h00;
            r_op_b     <= 8'h00;
            r_rsp_data <= 8'h00;
            r_cnt      <= 3'd0;
            r_first    <= 1'b0;
`ifndef FP8_ARB_FIXED_PRIO_EN
            r_rr_last  <= 1'b1;
`endif
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_any) begin
                        r_op_a    <= w_gnt1 ? req1_a : req0_a;
                        r_op_b    <= w_gnt1 ? req1_b : req0_b;
                        r_gid     <= w_gnt1;
`ifndef FP8_ARB_FIXED_PRIO_EN
                        r_rr_last <= w_gnt1;
`endif
                        r_state   <= StIssue;
                    end
                end
                StIssue: begin
                    if (ADD_LATENCY <= 1) begin
                        r_state <= StResp;
                        r_first <= 1'b1;
                    end else begin
                        r_cnt   <= WaitInit;
                        r_state <= StWait;
                    end
                end
                StWait: begin
                    if (r_cnt <= 3'd1) begin
                        r_cnt   <= 3'd0;
                        r_first <= 1'b1;
                        r_state <= StResp;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                StResp: begin
                    r_first <= 1'b0;
                    if (r_first) begin
                        r_rsp_data <= add_sum;
                    end
                    if (w_rsp_hs) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign req0_ready = w_grant & ~w_gnt1;
    assign req1_ready = w_grant & w_gnt1;
    assign add_en     = rst_n & (r_state == StIssue);
    assign add_a      = w_add_busy ? r_op_a : 8'h00;
    assign add_b      = w_add_busy ? r_op_b : 8'h00;
    assign rsp0_valid = w_resp & ~r_gid;
    assign rsp1_valid = w_resp & r_gid;
    // The adder result first appears in the RESP entry cycle, so pass it through until latched.
    assign rsp_data   = !rst_n ? 8'h00 : (r_first ? add_sum : r_rsp_data);

endmodule
